// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decodes MIPS ALU ops into the 3-bit ALU control interface
// and holds operands, control and writeback/branch qualifiers in one registered slot.
module alu_op_issue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [15:0]       imm,
    input  logic [REG_AW-1:0] rt_num,
    input  logic [REG_AW-1:0] rd_num,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    output logic [REG_AW-1:0] dest_num,
    output logic              reg_write,
    output logic              is_branch,
    output logic              branch_ne,
    output logic              mem_op,
    output logic              illegal
);

    localparam int unsigned IMM_W = 16;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    logic [DATA_W-1:0] d_a;
    logic [DATA_W-1:0] d_b;
    logic [2:0]        d_ctrl;
    logic [REG_AW-1:0] d_dest;
    logic              d_rw;
    logic              d_br;
    logic              d_bne;
    logic              d_mem;
    logic              d_ill;

    logic              accept;

    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};

    // Slot frees up when empty or when its op leaves this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Instruction decode and operand selection
    always_comb begin
        d_a    = rs_val;
        d_b    = '0;
        d_ctrl = ALU_ADD;
        d_dest = '0;
        d_rw   = 1'b0;
        d_br   = 1'b0;
        d_bne  = 1'b0;
        d_mem  = 1'b0;
        d_ill  = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                d_b    = rt_val;
                d_dest = rd_num;
                d_rw   = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: d_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: d_ctrl = ALU_SUB;
                    FN_AND:          d_ctrl = ALU_AND;
                    FN_OR:           d_ctrl = ALU_OR;
                    FN_XOR:          d_ctrl = ALU_XOR;
                    FN_NOR:          d_ctrl = ALU_NOR;
                    FN_SLT:          d_ctrl = ALU_SLT;
                    FN_SLTU:         d_ctrl = ALU_SLTU;
                    default:         d_ill  = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                d_b    = imm_sext;
                d_dest = rt_num;
                d_rw   = 1'b1;
                case (opcode)
                    OP_SLTI:  d_ctrl = ALU_SLT;
                    OP_SLTIU: d_ctrl = ALU_SLTU;
                    default:  d_ctrl = ALU_ADD;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                d_b    = imm_zext;
                d_dest = rt_num;
                d_rw   = 1'b1;
                case (opcode)
                    OP_ANDI: d_ctrl = ALU_AND;
                    OP_ORI:  d_ctrl = ALU_OR;
                    default: d_ctrl = ALU_XOR;
                endcase
            end
            OP_LW: begin
                d_b    = imm_sext;
                d_dest = rt_num;
                d_rw   = 1'b1;
                d_mem  = 1'b1;
            end
            OP_SW: begin
                d_b    = imm_sext;
                d_mem  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d_b    = rt_val;
                d_ctrl = ALU_SUB;
                d_br   = 1'b1;
                d_bne  = (opcode == OP_BNE);
            end
            default: d_ill = 1'b1;
        endcase

        // Traps carry no operands and no side effects
        if (d_ill) begin
            d_a    = '0;
            d_b    = '0;
            d_ctrl = ALU_ADD;
            d_dest = '0;
            d_rw   = 1'b0;
            d_br   = 1'b0;
            d_bne  = 1'b0;
            d_mem  = 1'b0;
        end
    end

    // Output slot; qualifiers are cleared whenever the slot goes empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= ALU_ADD;
            dest_num  <= '0;
            reg_write <= 1'b0;
            is_branch <= 1'b0;
            branch_ne <= 1'b0;
            mem_op    <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            reg_write <= 1'b0;
            is_branch <= 1'b0;
            mem_op    <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_a     <= d_a;
            alu_b     <= d_b;
            alu_ctrl  <= d_ctrl;
            dest_num  <= d_dest;
            reg_write <= d_rw;
            is_branch <= d_br;
            branch_ne <= d_bne;
            mem_op    <= d_mem;
            illegal   <= d_ill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            reg_write <= 1'b0;
            is_branch <= 1'b0;
            mem_op    <= 1'b0;
            illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed plan steps followed by random traffic,
// checked against a table-driven decode model and a one-deep delivery queue.
module tb_alu_op_issue;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        rw;
        logic        br;
        logic        bne;
        logic        mem;
        logic        ill;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic [4:0]  rt_num;
    logic [4:0]  rd_num;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [4:0]  dest_num;
    logic        reg_write;
    logic        is_branch;
    logic        branch_ne;
    logic        mem_op;
    logic        illegal;

    int npass = 0;
    int ntot  = 0;

    int   rtab [64];
    int   itab [64];
    op_t  q [$];
    int   dl [$];
    bit   zero_state;

    logic [5:0] op_pool [12];
    logic [5:0] fn_pool [10];

    alu_op_issue #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .rt_num(rt_num), .rd_num(rd_num), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a),
        .alu_b(alu_b), .alu_ctrl(alu_ctrl), .dest_num(dest_num),
        .reg_write(reg_write), .is_branch(is_branch), .branch_ne(branch_ne),
        .mem_op(mem_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Expected op from the instruction tables; -1 in a table means unsupported
    function automatic op_t model(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [15:0] im, input logic [4:0] rtn,
                                  input logic [4:0] rdn);
        op_t o;
        int  code;
        o = '0;
        code = (op == 0) ? rtab[fn] : itab[op];
        if (code < 0) begin
            o.ill = 1'b1;
            return o;
        end
        o.ctrl = 3'(code);
        o.a    = rs;
        if (op == 0) begin
            o.b = rt; o.dest = rdn; o.rw = 1'b1;
        end else if (op == 4 || op == 5) begin
            o.b = rt; o.br = 1'b1; o.bne = (op == 5);
        end else begin
            if (op >= 12 && op <= 14)      o.b = 32'(im);
            else if (im >= 16'h8000)       o.b = 32'(im) + 32'hFFFF_0000;
            else                           o.b = 32'(im);
            o.mem  = (op == 6'h23 || op == 6'h2B);
            o.rw   = (op != 6'h2B);
            o.dest = o.rw ? rtn : 5'd0;
        end
        return o;
    endfunction

    // One clock: check outputs at negedge, advance the model, return after posedge
    task automatic step();
        op_t e;
        bit  exp_ready;
        @(negedge clk);
        exp_ready = (q.size() == 0) || out_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            e = q[0];
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
            chk("reg_write", 32'(reg_write), 32'(e.rw));
            chk("is_branch", 32'(is_branch), 32'(e.br));
            chk("branch_ne", 32'(branch_ne), 32'(e.bne));
            chk("mem_op", 32'(mem_op), 32'(e.mem));
            chk("illegal", 32'(illegal), 32'(e.ill));
            if (e.rw) chk("dest_num", 32'(dest_num), 32'(e.dest));
        end else begin
            chk("idle_quals", {28'd0, reg_write, mem_op, is_branch, illegal}, 32'd0);
            if (zero_state) begin
                chk("rst_a", alu_a, 32'd0);
                chk("rst_b", alu_b, 32'd0);
                chk("rst_misc", {24'd0, alu_ctrl, dest_num}, 32'd0);
                chk("rst_bne", 32'(branch_ne), 32'd0);
            end
        end
        if (!rst_n) begin
            q.delete();
            zero_state = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) begin
                dl.push_back(int'(dest_num));
                void'(q.pop_front());
            end
            if (in_valid && exp_ready) begin
                q.push_back(model(opcode, funct, rs_val, rt_val, imm, rt_num, rd_num));
                zero_state = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                         input logic [4:0] rtn, input logic [4:0] rdn);
        in_valid = v; opcode = op; funct = fn; rs_val = rs; rt_val = rt;
        imm = im; rt_num = rtn; rd_num = rdn;
    endtask

    initial begin
        logic [2:0] rdy_pat;
        int idx;
        bit acc;

        foreach (rtab[i]) rtab[i] = -1;
        foreach (itab[i]) itab[i] = -1;
        rtab[32] = 0; rtab[33] = 0; rtab[34] = 1; rtab[35] = 1; rtab[36] = 2;
        rtab[37] = 3; rtab[38] = 4; rtab[39] = 5; rtab[42] = 6; rtab[43] = 7;
        itab[8] = 0; itab[9] = 0; itab[10] = 6; itab[11] = 7; itab[12] = 2;
        itab[13] = 3; itab[14] = 4; itab[35] = 0; itab[43] = 0; itab[4] = 1; itab[5] = 1;
        op_pool = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h05};
        fn_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

        zero_state = 1'b1;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Reset while an op is stalled
        out_ready = 1'b0;
        drive(1, 6'h00, 6'h20, 32'h1234_5678, 32'h1, 0, 0, 5'd3);
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        chk("rst_stall_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_a", alu_a, 32'd0);
        chk("rst_stall_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1; out_ready = 1'b1;

        drive(1, 6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 0, 5'd4, 5'd9);
        step();
        chk("slt_ctrl", 32'(alu_ctrl), 32'd6);
        chk("slt_b", alu_b, 32'h1);
        chk("slt_dest", 32'(dest_num), 32'd9);

        drive(1, 6'h08, 0, 32'h10, 32'h0, 16'h8000, 5'd6, 5'd0);
        step();
        chk("addi_b", alu_b, 32'hFFFF_8000);

        drive(1, 6'h0D, 0, 32'h10, 32'h0, 16'h8000, 5'd7, 5'd0);
        step();
        chk("ori_b", alu_b, 32'h0000_8000);
        chk("ori_ctrl_dest", {24'd0, alu_ctrl, dest_num}, {24'd0, 3'b011, 5'd7});

        drive(1, 6'h05, 0, 32'd5, 32'd5, 16'h0010, 5'd1, 5'd0);
        step();
        chk("bne_quals", {27'd0, alu_ctrl, is_branch, branch_ne}, {27'd0, 3'b001, 2'b11});
        chk("bne_z", 32'((alu_a - alu_b) == 0), 32'd1);
        in_valid = 1'b0;
        step();

        // Three ops through a 1,0,0,1,1 ready pattern
        dl.delete();
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            rdy_pat = 3'd0;
            out_ready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            drive(idx < 3, 6'h00, 6'h20, 32'(idx * 7), 32'h5, 0, 0, 5'(idx + 1));
            acc = in_valid && ((q.size() == 0) || out_ready);
            step();
            if (acc) idx++;
        end
        chk("bp_count", 32'(dl.size()), 32'd3);
        for (int i = 0; i < dl.size() && i < 3; i++) chk("bp_order", 32'(dl[i]), 32'(i + 1));

        // Flush with a held op and a same-cycle incoming op
        out_ready = 1'b0;
        drive(1, 6'h23, 0, 32'h100, 0, 16'h0004, 5'd2, 5'd0);
        step();
        drive(1, 6'h00, 6'h25, 32'h1, 32'h2, 0, 0, 5'd8);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_quals", {28'd0, reg_write, mem_op, is_branch, illegal}, 32'd0);
        step();
        chk("flush_gone", 32'(out_valid), 32'd0);

        out_ready = 1'b1;
        drive(1, 6'h3F, 0, 32'hDEAD_BEEF, 32'h1, 16'h1234, 5'd3, 5'd4);
        step();
        chk("ill_flags", {28'd0, out_valid, illegal, reg_write, 1'b0}, {28'd0, 4'b1100});
        chk("ill_ctrl", 32'(alu_ctrl), 32'd0);
        in_valid = 1'b0;
        step();

        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            opcode    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                    : op_pool[$urandom_range(0, 11)];
            funct     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                    : fn_pool[$urandom_range(0, 9)];
            rs_val    = $urandom;
            rt_val    = $urandom;
            imm       = 16'($urandom);
            rt_num    = 5'($urandom);
            rd_num    = 5'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
